// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry block: FSM states, frame results and the keymap.
package keypad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DEB, ST_HELD, ST_REL} state_t;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  function automatic logic [3:0] map_key(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad entry bus: clear request, matrix row/column lines and the assembled entry.
interface keypad_entry_if;
  logic       clr_tgl;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] p0, p1, p2, p3;
  logic [2:0] digit_cnt;
  logic       key_valid;
  logic [3:0] key_code;

  modport master (output clr_tgl, row,
                  input  col, p0, p1, p2, p3, digit_cnt, key_valid, key_code);
  modport slave  (input  clr_tgl, row,
                  output col, p0, p1, p2, p3, digit_cnt, key_valid, key_code);
endinterface

// File: rtl/keypad_col_scanner.sv
// Column scanner: slot divider, column rotation, row synchronizer and per-frame key summary.
module keypad_col_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       frame_done,
  output frame_t     frame_res,
  output logic [3:0] frame_code
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [3:0]       row_s1, row_s2;
  logic [1:0]       acc_cnt;
  logic [3:0]       acc_code;
  logic             slot_end;
  logic [2:0]       slot_hits;
  logic [1:0]       slot_row;
  logic [2:0]       sum;
  logic [1:0]       tot;
  logic [3:0]       tot_code;

  assign slot_end = (div == DIV_LAST);

  // Key count saturates at 2: anything beyond one key is a ghost-prone frame.
  always_comb begin
    slot_hits = '0;
    slot_row  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2[r]) begin
        slot_hits = slot_hits + 3'd1;
        slot_row  = 2'(r);
      end
    end
    sum      = {1'b0, acc_cnt} + slot_hits;
    tot      = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (acc_cnt == 2'd0) ? map_key(slot_row, col_idx) : acc_code;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div        <= '0;
      col_idx    <= '0;
      col        <= 4'b1110;
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      acc_cnt    <= '0;
      acc_code   <= '0;
      frame_done <= 1'b0;
      frame_res  <= FR_NONE;
      frame_code <= '0;
    end else begin
      row_s1     <= row;
      row_s2     <= row_s1;
      frame_done <= 1'b0;
      if (slot_end) begin
        div     <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx == 2'd3) begin
          frame_done <= 1'b1;
          frame_res  <= (tot == 2'd0) ? FR_NONE : (tot == 2'd1) ? FR_SINGLE : FR_MULTI;
          frame_code <= tot_code;
          acc_cnt    <= '0;
          acc_code   <= '0;
        end else begin
          acc_cnt  <= tot;
          acc_code <= tot_code;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top: debounce FSM, 4-digit entry shift register and clear handling.
// KEYPAD_HEX_DIGITS_EN: when defined all 16 keys shift in; otherwise only 0-9, '*' clears.
//
// state | meaning
// IDLE  | no key, waiting for a single-key frame
// DEB   | candidate seen, counting identical frames
// HELD  | press accepted, waiting for release (no auto-repeat)
// REL   | counting key-free frames before re-arming
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_if.slave bus
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  logic       frame_done;
  frame_t     frame_res;
  logic [3:0] frame_code;
  state_t     state;
  logic [3:0] cand, cnt;
  logic       clr_s1, clr_s2, clr_d, clr_edge;
  logic       accept, is_digit, is_star_clr;
  logic [3:0] accept_code;
  logic [3:0] p0, p1, p2, p3, key_code;
  logic [2:0] digit_cnt;
  logic       key_valid;

  keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row        (bus.row),
    .col        (bus.col),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign clr_edge    = clr_s2 ^ clr_d;
  assign accept_code = (state == ST_IDLE) ? frame_code : cand;

  always_comb begin
    accept = 1'b0;
    if (frame_done) begin
      case (state)
        ST_IDLE: accept = (frame_res == FR_SINGLE) && (DEB_N == 4'd1);
        ST_DEB:  accept = (frame_res == FR_SINGLE) && (frame_code == cand) &&
                          (cnt + 4'd1 == DEB_N);
        default: accept = 1'b0;
      endcase
    end
  end

`ifdef KEYPAD_HEX_DIGITS_EN
  assign is_digit    = 1'b1;
  assign is_star_clr = 1'b0;
`else
  assign is_digit    = (accept_code <= 4'h9);
  assign is_star_clr = (accept_code == KEY_STAR);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      clr_s1    <= 1'b0;
      clr_s2    <= 1'b0;
      clr_d     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= '0;
      p0        <= '0;
      p1        <= '0;
      p2        <= '0;
      p3        <= '0;
      digit_cnt <= '0;
    end else begin
      clr_s1    <= bus.clr_tgl;
      clr_s2    <= clr_s1;
      clr_d     <= clr_s2;
      key_valid <= accept;
      if (accept) key_code <= accept_code;

      if (frame_done) begin
        case (state)
          ST_IDLE: if (frame_res == FR_SINGLE) begin
            cand  <= frame_code;
            cnt   <= 4'd1;
            state <= (DEB_N == 4'd1) ? ST_HELD : ST_DEB;
          end
          ST_DEB: if (frame_res == FR_SINGLE && frame_code == cand) begin
            cnt <= cnt + 4'd1;
            if (accept) state <= ST_HELD;
          end else begin
            state <= ST_IDLE;
          end
          ST_HELD: if (frame_res != FR_SINGLE) begin
            cnt   <= 4'd1;
            state <= (DEB_N == 4'd1) ? ST_IDLE : ST_REL;
          end
          default: if (frame_res == FR_SINGLE) begin
            state <= ST_HELD;
          end else if (cnt + 4'd1 == DEB_N) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        endcase
      end

      // A clear request beats a simultaneous digit; key_valid still reports the press.
      if (clr_edge || (accept && is_star_clr)) begin
        p0        <= '0;
        p1        <= '0;
        p2        <= '0;
        p3        <= '0;
        digit_cnt <= '0;
      end else if (accept && is_digit) begin
        p3        <= p2;
        p2        <= p1;
        p1        <= p0;
        p0        <= accept_code;
        digit_cnt <= (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
      end
    end
  end

  assign bus.p0        = p0;
  assign bus.p1        = p1;
  assign bus.p2        = p2;
  assign bus.p3        = p3;
  assign bus.digit_cnt = digit_cnt;
  assign bus.key_valid = key_valid;
  assign bus.key_code  = key_code;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16 clk per frame).
`timescale 1ns/1ps
module tb_keypad_entry;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_entry_if bus ();

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Matrix model: a pressed key pulls its row low while its column is driven.
  logic [15:0] keys_dn;
  logic [3:0]  row_v;
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_dn[r*4+c] && !bus.col[c]) row_v[r] = 1'b0;
    bus.row = row_v;
  end

  int pulses = 0;
  always @(negedge clk) if (bus.key_valid === 1'b1) pulses <= pulses + 1;

  logic [15:0] pw;
  assign pw = {bus.p3, bus.p2, bus.p1, bus.p0};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_col_enter(input logic [3:0] target);
    int n;
    n = 0;
    while (bus.col == target && n < 40) begin @(negedge clk); n++; end
    while (bus.col != target && n < 80) begin @(negedge clk); n++; end
    if (bus.col != target) begin
      checks++;
      errors++;
      $display("FAIL wait_col actual=%b required=%b", bus.col, target);
    end
  endtask

  typedef struct {
    int         r;
    int         c;
    bit         press;
    int         hold;
    int         rel;
    int         exp_pulses;
    logic [3:0] exp_code;
    logic [15:0] exp_p;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic run_vec(input vec_t v, input string tag);
    int base;
    base = pulses;
    if (v.press) keys_dn[v.r*4+v.c] = 1'b1;
    repeat (v.hold*16) @(negedge clk);
    keys_dn = '0;
    repeat (v.rel*16) @(negedge clk);
    check({tag, "_pulses"}, pulses - base, v.exp_pulses);
    check({tag, "_code"}, bus.key_code, v.exp_code);
    check({tag, "_p"}, pw, v.exp_p);
    check({tag, "_cnt"}, bus.digit_cnt, v.exp_cnt);
  endtask

  initial begin
    int base;
    keys_dn     = '0;
    bus.clr_tgl = 1'b0;

    vecs[0]  = '{2, 1, 1'b1, 13, 4, 1, 4'h8, 16'h0008, 3'd1};
    vecs[1]  = '{0, 0, 1'b0,  3, 0, 0, 4'h8, 16'h0008, 3'd1};
    vecs[2]  = '{0, 0, 1'b1,  3, 4, 1, 4'h1, 16'h0081, 3'd2};
    vecs[3]  = '{0, 1, 1'b1,  3, 4, 1, 4'h2, 16'h0812, 3'd3};
    vecs[4]  = '{0, 2, 1'b1,  3, 4, 1, 4'h3, 16'h8123, 3'd4};
    vecs[5]  = '{1, 0, 1'b1,  3, 4, 1, 4'h4, 16'h1234, 3'd4};
    vecs[6]  = '{1, 1, 1'b1,  3, 4, 1, 4'h5, 16'h2345, 3'd4};
`ifdef KEYPAD_HEX_DIGITS_EN
    vecs[7]  = '{0, 3, 1'b1,  3, 4, 1, 4'hA, 16'h345A, 3'd4};
    vecs[8]  = '{3, 0, 1'b1,  3, 4, 1, 4'hE, 16'h45AE, 3'd4};
    vecs[9]  = '{3, 1, 1'b1,  3, 4, 1, 4'h0, 16'h5AE0, 3'd4};
    vecs[10] = '{3, 2, 1'b1,  3, 4, 1, 4'hF, 16'hAE0F, 3'd4};
    vecs[11] = '{3, 3, 1'b1,  3, 4, 1, 4'hD, 16'hE0FD, 3'd4};
    vecs[12] = '{2, 2, 1'b1,  3, 4, 1, 4'h9, 16'h0FD9, 3'd4};
    vecs[13] = '{2, 3, 1'b1,  3, 4, 1, 4'hC, 16'hFD9C, 3'd4};
    vecs[14] = '{1, 2, 1'b1,  3, 4, 1, 4'h6, 16'hD9C6, 3'd4};
    vecs[15] = '{1, 3, 1'b1,  3, 4, 1, 4'hB, 16'h9C6B, 3'd4};
    vecs[16] = '{2, 0, 1'b1,  3, 4, 1, 4'h7, 16'hC6B7, 3'd4};
`else
    vecs[7]  = '{0, 3, 1'b1,  3, 4, 1, 4'hA, 16'h2345, 3'd4};
    vecs[8]  = '{3, 0, 1'b1,  3, 4, 1, 4'hE, 16'h0000, 3'd0};
    vecs[9]  = '{3, 1, 1'b1,  3, 4, 1, 4'h0, 16'h0000, 3'd1};
    vecs[10] = '{3, 2, 1'b1,  3, 4, 1, 4'hF, 16'h0000, 3'd1};
    vecs[11] = '{3, 3, 1'b1,  3, 4, 1, 4'hD, 16'h0000, 3'd1};
    vecs[12] = '{2, 2, 1'b1,  3, 4, 1, 4'h9, 16'h0009, 3'd2};
    vecs[13] = '{2, 3, 1'b1,  3, 4, 1, 4'hC, 16'h0009, 3'd2};
    vecs[14] = '{1, 2, 1'b1,  3, 4, 1, 4'h6, 16'h0096, 3'd3};
    vecs[15] = '{1, 3, 1'b1,  3, 4, 1, 4'hB, 16'h0096, 3'd3};
    vecs[16] = '{2, 0, 1'b1,  3, 4, 1, 4'h7, 16'h0967, 3'd4};
`endif

    repeat (3) @(negedge clk);
    check("rst_col", bus.col, 4'b1110);
    check("rst_p", pw, 16'h0000);
    check("rst_cnt", bus.digit_cnt, 3'd0);
    check("rst_valid", bus.key_valid, 1'b0);
    check("rst_code", bus.key_code, 4'h0);

    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("col_slot1", bus.col, 4'b1101);
    repeat (4) @(negedge clk);
    check("col_slot2", bus.col, 4'b1011);
    repeat (4) @(negedge clk);
    check("col_slot3", bus.col, 4'b0111);
    repeat (4) @(negedge clk);
    check("col_wrap", bus.col, 4'b1110);

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    bus.clr_tgl = 1'b1;
    repeat (6) @(negedge clk);
    check("clr_rise_p", pw, 16'h0000);
    check("clr_rise_cnt", bus.digit_cnt, 3'd0);
    run_vec('{0, 2, 1'b1, 3, 4, 1, 4'h3, 16'h0003, 3'd1}, "after_clr");
    bus.clr_tgl = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_fall_p", pw, 16'h0000);
    check("clr_fall_cnt", bus.digit_cnt, 3'd0);
    run_vec('{0, 2, 1'b1, 3, 4, 1, 4'h3, 16'h0003, 3'd1}, "refill");

    // Clear edge timed to land on the same cycle as the accept of key 7.
    base = pulses;
    wait_col_enter(4'b1110);
    keys_dn[8] = 1'b1;
    wait_col_enter(4'b0111);
    wait_col_enter(4'b1110);
    wait_col_enter(4'b0111);
    @(negedge clk);
    @(negedge clk);
    bus.clr_tgl = 1'b1;
    repeat (6) @(negedge clk);
    check("clr_acc_pulses", pulses - base, 1);
    check("clr_acc_code", bus.key_code, 4'h7);
    check("clr_acc_p", pw, 16'h0000);
    check("clr_acc_cnt", bus.digit_cnt, 3'd0);
    keys_dn = '0;
    repeat (64) @(negedge clk);

    base = pulses;
    for (int k = 0; k < 4; k++) begin
      keys_dn[5] = 1'b1;
      repeat (16) @(negedge clk);
      keys_dn = '0;
      repeat (16) @(negedge clk);
    end
    repeat (64) @(negedge clk);
    check("bounce_pulses", pulses - base, 0);

    base = pulses;
    keys_dn[0]  = 1'b1;
    keys_dn[10] = 1'b1;
    repeat (96) @(negedge clk);
    keys_dn = '0;
    repeat (64) @(negedge clk);
    check("ghost_pulses", pulses - base, 0);

    // Reset while key 2 is in DEB and still held: it must be debounced from scratch.
    wait_col_enter(4'b1110);
    keys_dn[1] = 1'b1;
    wait_col_enter(4'b0111);
    wait_col_enter(4'b1110);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_code", bus.key_code, 4'h0);
    @(negedge clk);
    base = pulses;
    rst = 1'b1;
    repeat (24) @(negedge clk);
    check("rst_mid_early", pulses - base, 0);
    repeat (40) @(negedge clk);
    check("rst_mid_pulses", pulses - base, 1);
    check("rst_mid_p", pw, 16'h0002);
    check("rst_mid_cnt", bus.digit_cnt, 3'd1);
    keys_dn = '0;
    repeat (64) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
